// File: rtl/memory_cycle_if.sv
// Data-memory bus between the MEM stage and the data memory.
// Request side (req/we/addr/wdata/wstrb) is driven by the MEM stage;
// the memory returns rdata together with ready.
interface memory_cycle_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;

    modport master (output req, we, addr, wdata, wstrb, input rdata, ready);
    modport slave  (input req, we, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/memory_cycle.sv
// MEM pipeline stage: issues loads/stores on the data bus, stalls the
// front of the pipe while the memory is not ready, formats store data and
// extends load data, flags misaligned/illegal accesses and drives MEM/WB.
module memory_cycle (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ALUResultM,
    input  logic [31:0]       WriteDataM,
    input  logic [31:0]       PCPlus4M,
    input  logic [31:0]       InstrM,
    input  logic [4:0]        RdM,
    input  logic              RegWriteM,
    input  logic              MemWriteM,
    input  logic [1:0]        ResultSrcM,
    memory_cycle_if.master    dmem,
    output logic [31:0]       ALUResultW,
    output logic [31:0]       ReadDataW,
    output logic [31:0]       PCPlus4W,
    output logic [4:0]        RdW,
    output logic              RegWriteW,
    output logic [1:0]        ResultSrcW,
    output logic              StallM,
    output logic              MisalignM
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t state_q, state_d;

    // Request captured when the memory is not ready in the first cycle.
    logic [31:0] lat_addr, lat_wdata, lat_alu, lat_pc4;
    logic [3:0]  lat_wstrb;
    logic [2:0]  lat_f3;
    logic [4:0]  lat_rd;
    logic [1:0]  lat_rsrc;
    logic        lat_we, lat_rw;

    logic [2:0] funct3;
    logic       is_store, is_load, access, fault, go_wait;
    logic       unused_instr_bits;

    assign funct3   = InstrM[14:12];
    assign is_store = MemWriteM;
    assign is_load  = !MemWriteM && (ResultSrcM == 2'b01);
    assign access   = is_store || is_load;
    assign fault    = access && access_fault(is_store, funct3, ALUResultM[1:0]);
    assign unused_instr_bits = ^{InstrM[31:15], InstrM[11:0]};

    function automatic logic access_fault(input logic st, input logic [2:0] f3,
                                          input logic [1:0] a);
        logic f;
        case (f3)
            3'b000:  f = 1'b0;
            3'b001:  f = a[0];
            3'b010:  f = (a != 2'b00);
            3'b100:  f = st;
            3'b101:  f = st || a[0];
            default: f = 1'b1;
        endcase
        return f;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  return {4{d[7:0]}};
            3'b001:  return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000:  return 4'b0001 << a;
            3'b001:  return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] r);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = r[7:0];
            2'd1:    b = r[15:8];
            2'd2:    b = r[23:16];
            default: b = r[31:24];
        endcase
        h = a[1] ? r[31:16] : r[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return r;
        endcase
    endfunction

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state, bus drive, stall and fault outputs; reset forces all quiet.
    always_comb begin
        state_d       = state_q;
        dmem.req      = 1'b0;
        dmem.we       = 1'b0;
        dmem.addr     = 32'd0;
        dmem.wdata    = 32'd0;
        dmem.wstrb    = 4'd0;
        StallM        = 1'b0;
        MisalignM     = 1'b0;
        go_wait       = 1'b0;
        case (state_q)
            IDLE: begin
                if (access && fault) begin
                    MisalignM = 1'b1;
                end else if (access) begin
                    dmem.req   = 1'b1;
                    dmem.we    = is_store;
                    dmem.addr  = {ALUResultM[31:2], 2'b00};
                    dmem.wdata = is_store ? store_data(funct3, WriteDataM) : 32'd0;
                    dmem.wstrb = is_store ? store_strb(funct3, ALUResultM[1:0]) : 4'd0;
                    if (!dmem.ready) begin
                        StallM  = 1'b1;
                        go_wait = 1'b1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                dmem.req   = 1'b1;
                dmem.we    = lat_we;
                dmem.addr  = {lat_addr[31:2], 2'b00};
                dmem.wdata = lat_wdata;
                dmem.wstrb = lat_we ? lat_wstrb : 4'd0;
                if (dmem.ready) state_d = IDLE;
                else            StallM  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            state_d    = IDLE;
            dmem.req   = 1'b0;
            dmem.we    = 1'b0;
            dmem.wstrb = 4'd0;
            StallM     = 1'b0;
            MisalignM  = 1'b0;
            go_wait    = 1'b0;
        end
    end

    // Capture the pending request and its MEM/WB payload on entry to WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_addr <= '0; lat_wdata <= '0; lat_wstrb <= '0; lat_we <= 1'b0;
            lat_f3 <= '0; lat_alu <= '0; lat_pc4 <= '0; lat_rd <= '0;
            lat_rw <= 1'b0; lat_rsrc <= '0;
        end else if (go_wait) begin
            lat_addr  <= ALUResultM;
            lat_wdata <= is_store ? store_data(funct3, WriteDataM) : 32'd0;
            lat_wstrb <= is_store ? store_strb(funct3, ALUResultM[1:0]) : 4'd0;
            lat_we    <= is_store;
            lat_f3    <= funct3;
            lat_alu   <= ALUResultM;
            lat_pc4   <= PCPlus4M;
            lat_rd    <= RdM;
            lat_rw    <= RegWriteM;
            lat_rsrc  <= ResultSrcM;
        end
    end

    // MEM/WB register: bubble on stall or fault, else latched or live payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || StallM || (state_q == IDLE && fault)) begin
            ALUResultW <= '0; ReadDataW <= '0; PCPlus4W <= '0;
            RdW <= '0; RegWriteW <= 1'b0; ResultSrcW <= '0;
        end else if (state_q == WAIT) begin
            ALUResultW <= lat_alu;
            ReadDataW  <= lat_we ? 32'd0 : load_ext(lat_f3, lat_addr[1:0], dmem.rdata);
            PCPlus4W   <= lat_pc4;
            RdW        <= lat_rd;
            RegWriteW  <= lat_rw;
            ResultSrcW <= lat_rsrc;
        end else begin
            ALUResultW <= ALUResultM;
            ReadDataW  <= is_load ? load_ext(funct3, ALUResultM[1:0], dmem.rdata) : 32'd0;
            PCPlus4W   <= PCPlus4M;
            RdW        <= RdM;
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
        end
    end

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for the MEM stage: zero-wait and wait-state accesses,
// store formatting, load extension, faults and reset behaviour.
module tb_memory_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M, InstrM;
    logic [4:0]  RdM;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  RdW;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic        StallM, MisalignM;

    int total = 0;
    int bad   = 0;

    memory_cycle_if dmem ();

    memory_cycle dut (
        .clk(clk), .rst(rst),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .InstrM(InstrM), .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .dmem(dmem),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
        .RdW(RdW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .StallM(StallM), .MisalignM(MisalignM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic put(input logic st, input logic [1:0] rs, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                       input logic rw, input logic [31:0] pc4);
        MemWriteM  = st;
        ResultSrcM = rs;
        InstrM     = {17'd0, f3, 5'd0, 7'b0000011};
        ALUResultM = a;
        WriteDataM = wd;
        RdM        = rd;
        RegWriteM  = rw;
        PCPlus4M   = pc4;
    endtask

    task automatic idle_in();
        put(1'b0, 2'b00, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        // Reset held with a valid load presented and ready high.
        rst = 1'b1;
        dmem.ready = 1'b1;
        dmem.rdata = 32'hDEADBEEF;
        put(1'b0, 2'b01, 3'b010, 32'h100, 32'd0, 5'd5, 1'b1, 32'h104);
        #1;
        chk("rst_req", dmem.req, 1'b0);
        chk("rst_stall", StallM, 1'b0);
        chk("rst_wstrb", dmem.wstrb, 4'd0);
        step();
        chk("rst_aluW", ALUResultW, 32'd0);
        chk("rst_rdW", RdW, 5'd0);
        chk("rst_rwW", RegWriteW, 1'b0);
        rst = 1'b0;

        // Zero-wait LW.
        #1;
        chk("lw_req", dmem.req, 1'b1);
        chk("lw_addr", dmem.addr, 32'h100);
        chk("lw_we", dmem.we, 1'b0);
        chk("lw_wstrb", dmem.wstrb, 4'd0);
        chk("lw_stall", StallM, 1'b0);
        step();
        chk("lw_data", ReadDataW, 32'hDEADBEEF);
        chk("lw_rw", RegWriteW, 1'b1);
        chk("lw_rd", RdW, 5'd5);
        chk("lw_pc4", PCPlus4W, 32'h104);
        chk("lw_rsrc", ResultSrcW, 2'b01);

        // LB at 0x103 with two wait states.
        put(1'b0, 2'b01, 3'b000, 32'h103, 32'd0, 5'd6, 1'b1, 32'h200);
        dmem.ready = 1'b0;
        dmem.rdata = 32'd0;
        #1;
        chk("lb_stall1", StallM, 1'b1);
        chk("lb_req1", dmem.req, 1'b1);
        chk("lb_addr1", dmem.addr, 32'h100);
        step();
        chk("lb_bub1", RegWriteW, 1'b0);
        chk("lb_stall2", StallM, 1'b1);
        ALUResultM = 32'hFFFF_FFF0;
        RdM = 5'd31;
        #1;
        chk("lb_addr2", dmem.addr, 32'h100);
        chk("lb_req2", dmem.req, 1'b1);
        step();
        chk("lb_bub2", RegWriteW, 1'b0);
        dmem.ready = 1'b1;
        dmem.rdata = 32'h8000_0000;
        #1;
        chk("lb_stall3", StallM, 1'b0);
        step();
        chk("lb_data", ReadDataW, 32'hFFFFFF80);
        chk("lb_rw", RegWriteW, 1'b1);
        chk("lb_rd", RdW, 5'd6);
        chk("lb_alu", ALUResultW, 32'h103);

        // SH at 0x202.
        put(1'b1, 2'b00, 3'b001, 32'h202, 32'h1234ABCD, 5'd0, 1'b0, 32'h300);
        #1;
        chk("sh_wstrb", dmem.wstrb, 4'b1100);
        chk("sh_wdata", dmem.wdata, 32'hABCDABCD);
        chk("sh_we", dmem.we, 1'b1);
        chk("sh_addr", dmem.addr, 32'h200);
        step();
        chk("sh_rw", RegWriteW, 1'b0);
        chk("sh_rdata", ReadDataW, 32'd0);

        // SB at 0x201.
        put(1'b1, 2'b00, 3'b000, 32'h201, 32'h0000_0055, 5'd0, 1'b0, 32'h304);
        #1;
        chk("sb_wstrb", dmem.wstrb, 4'b0010);
        chk("sb_wdata", dmem.wdata, 32'h55555555);
        step();

        // Misaligned SW.
        put(1'b1, 2'b00, 3'b010, 32'h102, 32'h1, 5'd0, 1'b0, 32'h308);
        #1;
        chk("swmis_flag", MisalignM, 1'b1);
        chk("swmis_req", dmem.req, 1'b0);
        step();

        // Misaligned LW at 0x101.
        put(1'b0, 2'b01, 3'b010, 32'h101, 32'd0, 5'd9, 1'b1, 32'h30C);
        #1;
        chk("lwmis_req", dmem.req, 1'b0);
        chk("lwmis_flag", MisalignM, 1'b1);
        chk("lwmis_stall", StallM, 1'b0);
        step();
        chk("lwmis_rw", RegWriteW, 1'b0);
        chk("lwmis_rd", RdW, 5'd0);
        idle_in();
        #1;
        chk("lwmis_pulse", MisalignM, 1'b0);

        // Illegal load funct3 011.
        put(1'b0, 2'b01, 3'b011, 32'h100, 32'd0, 5'd4, 1'b1, 32'h310);
        #1;
        chk("ld011_flag", MisalignM, 1'b1);
        chk("ld011_req", dmem.req, 1'b0);
        step();

        // Non-access pass-through, ready high must be ignored.
        put(1'b0, 2'b10, 3'b000, 32'h12345678, 32'd0, 5'd7, 1'b1, 32'h44);
        #1;
        chk("pass_req", dmem.req, 1'b0);
        chk("pass_wstrb", dmem.wstrb, 4'd0);
        step();
        chk("pass_alu", ALUResultW, 32'h12345678);
        chk("pass_pc4", PCPlus4W, 32'h44);
        chk("pass_rd", RdW, 5'd7);
        chk("pass_rw", RegWriteW, 1'b1);
        chk("pass_rsrc", ResultSrcW, 2'b10);
        chk("pass_rdata", ReadDataW, 32'd0);

        // Asynchronous reset clears MEM/WB mid-cycle.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_alu", ALUResultW, 32'd0);
        chk("arst_rd", RdW, 5'd0);
        chk("arst_rw", RegWriteW, 1'b0);
        rst = 1'b0;
        step();

        // Reset during a pending LW, then ready after release.
        put(1'b0, 2'b01, 3'b010, 32'h200, 32'd0, 5'd3, 1'b1, 32'h404);
        dmem.ready = 1'b0;
        step();
        chk("wrst_req_pre", dmem.req, 1'b1);
        chk("wrst_stall_pre", StallM, 1'b1);
        rst = 1'b1;
        #1;
        chk("wrst_req", dmem.req, 1'b0);
        chk("wrst_stall", StallM, 1'b0);
        rst = 1'b0;
        idle_in();
        dmem.ready = 1'b1;
        #1;
        chk("wrst_req_post", dmem.req, 1'b0);
        chk("wrst_stall_post", StallM, 1'b0);
        step();
        chk("wrst_rw", RegWriteW, 1'b0);
        chk("wrst_alu", ALUResultW, 32'd0);
        chk("wrst_rdata", ReadDataW, 32'd0);

        // LHU and LH at 0x302.
        put(1'b0, 2'b01, 3'b101, 32'h302, 32'd0, 5'd3, 1'b1, 32'h500);
        dmem.rdata = 32'h8001FFFF;
        #1;
        chk("lhu_stall", StallM, 1'b0);
        step();
        chk("lhu_data", ReadDataW, 32'h00008001);
        put(1'b0, 2'b01, 3'b001, 32'h302, 32'd0, 5'd3, 1'b1, 32'h504);
        step();
        chk("lh_data", ReadDataW, 32'hFFFF8001);
        put(1'b0, 2'b01, 3'b100, 32'h101, 32'd0, 5'd3, 1'b1, 32'h508);
        dmem.rdata = 32'h0000_8000;
        step();
        chk("lbu_data", ReadDataW, 32'h00000080);

        // SW with one wait state: bus held from latches.
        put(1'b1, 2'b00, 3'b010, 32'h300, 32'hCAFEF00D, 5'd0, 1'b0, 32'h600);
        dmem.ready = 1'b0;
        #1;
        chk("sww_stall", StallM, 1'b1);
        chk("sww_wstrb", dmem.wstrb, 4'b1111);
        step();
        WriteDataM = 32'h1111_1111;
        InstrM = 32'd0;
        #1;
        chk("sww_wdata", dmem.wdata, 32'hCAFEF00D);
        chk("sww_wstrb2", dmem.wstrb, 4'b1111);
        chk("sww_we", dmem.we, 1'b1);
        dmem.ready = 1'b1;
        step();
        chk("sww_pc4", PCPlus4W, 32'h600);
        chk("sww_rdata", ReadDataW, 32'd0);
        idle_in();
        #1;
        chk("sww_idle_req", dmem.req, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_cycle.md
MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 SHALL have clock and reset ports: clk in 1, rising-edge clock; rst in 1, reset, asynchronous, active-high.
REQ-002 SHALL have the EX/MEM register inputs: ALUResultM, WriteDataM, PCPlus4M, InstrM in 32 each; RdM in 5; RegWriteM in 1; MemWriteM in 1; ResultSrcM in 2, where 01 = load.
REQ-003 SHALL have the data bus ports: dmem_req out 1; dmem_we out 1; dmem_addr out 32, word-aligned; dmem_wdata out 32; dmem_wstrb out 4; dmem_rdata in 32; dmem_ready in 1.
REQ-004 SHALL have the MEM/WB register outputs: ALUResultW, ReadDataW, PCPlus4W out 32 each; RdW out 5; RegWriteW out 1; ResultSrcW out 2.
REQ-005 SHALL have the control outputs: StallM out 1, freezes IF/ID/EX/EX-MEM registers; MisalignM out 1, one-cycle fault pulse.

Function
REQ-006 SHALL treat a cycle as an access when MemWriteM=1 (store) or ResultSrcM=01 (load); funct3 = InstrM[14:12]; addr = ALUResultM.
REQ-007 SHALL implement an FSM with two states: IDLE and WAIT.
REQ-008 In IDLE with an aligned access: dmem_req=1 the same cycle, driven combinationally from the M inputs; dmem_addr={addr[31:2],2'b00}; dmem_we=MemWriteM.
REQ-009 In IDLE, if dmem_ready=1 in the same cycle: access completes with zero wait, StallM=0, MEM/WB loads on the next edge, FSM stays IDLE.
REQ-010 In IDLE, if dmem_ready=0: StallM=1 combinationally; FSM -> WAIT; the block latches addr, we, wdata, wstrb, funct3, and the MEM/WB payload.
REQ-011 In WAIT: dmem_req=1 and the bus outputs are driven from the latches and held stable; StallM=1 until dmem_ready=1.
REQ-012 In WAIT with dmem_ready=1: StallM=0 that cycle; rdata is captured; MEM/WB loads from the latches; FSM -> IDLE.
REQ-013 While StallM=1 at a clock edge, the MEM/WB register SHALL load a bubble: RegWriteW=0, RdW=0, other fields don't-care but deterministic 0.
REQ-014 Stores SHALL use funct3 000 (SB), 001 (SH), 010 (SW).
- wdata: byte replicated x4, half replicated x2, word as-is.
- wstrb: SB 0001<<addr[1:0]; SH 0011 or 1100 by addr[1]; SW 1111.
REQ-015 Loads SHALL select the lane by addr[1:0] and extend it:
- 000 LB sign-extend; 001 LH sign-extend; 010 LW.
- 100 LBU zero-extend; 101 LHU zero-extend.
- Result goes to ReadDataW.
REQ-016 A fault SHALL be raised on any of the following:
- LH/LHU/SH with addr[0]=1;
- LW/SW with addr[1:0]!=0;
- a load funct3 in {011,110,111};
- a store funct3 not in {000,001,010}.
REQ-017 On a fault: no bus request; MisalignM=1 for one cycle; no stall; MEM/WB loads a bubble.
REQ-018 Non-access cycles SHALL pass through to MEM/WB on each edge with no bus activity: ALUResultW, PCPlus4W, RdW, RegWriteW, ResultSrcW; ReadDataW=0.
REQ-019 dmem_wstrb SHALL be 0000 whenever dmem_we=0 or dmem_req=0.
REQ-020 Stores SHALL pass RegWriteW through as presented (normally 0); this block does not force it.
REQ-021 M inputs arriving while in WAIT SHALL be ignored; upstream is frozen by StallM.

Reset
REQ-022 On rst=1 (asynchronous), the block SHALL:
- set FSM=IDLE;
- set all MEM/WB outputs to 0 and all latches to 0;
- drop dmem_req, dmem_we and dmem_wstrb to 0 immediately;
- force StallM=0 and MisalignM=0.
REQ-023 Reset asserted during WAIT SHALL abandon the transaction; a dmem_ready arriving after reset release SHALL be ignored while IDLE with no access.
REQ-024 After rst deassertion, the first edge SHALL process the M inputs normally.

Verification
REQ-025 Zero-wait LW: addr=0x100, ready=1 same cycle, rdata=0xDEADBEEF -> StallM=0; next edge ReadDataW=0xDEADBEEF, RegWriteW=1.
REQ-026 LB with 2 wait states: addr=0x103, rdata=0x80000000, ready on third cycle.
- StallM=1 for 2 cycles, with req/addr=0x100 held stable.
- ReadDataW=0xFFFFFF80.
- Bubble (RegWriteW=0) on the stalled edges.
REQ-027 SH: addr=0x202, WriteDataM=0x1234ABCD -> dmem_wstrb=1100, dmem_wdata=0xABCDABCD, dmem_we=1.
REQ-028 Misaligned LW at addr=0x101 -> dmem_req=0, MisalignM=1 for 1 cycle, StallM=0, RegWriteW=0.
REQ-029 rst pulsed in WAIT (LW pending), then ready=1 after release -> dmem_req=0, StallM=0, all W outputs 0, FSM IDLE.
REQ-030 LHU at addr=0x302, rdata=0x8001FFFF -> ReadDataW=0x00008001.
